lane_deskew: RTL and testbench

Two-lane deskew stage directly downstream of the lane decoder. It consumes the per-lane decoded byte streams plus the decoder's `enable_deskew` and `data_os` flags. It measures the inter-lane skew from one alignment-marker byte per lane and delays the leading lane so both lanes leave byte-aligned. Its outputs feed the receive-side framing logic.

---
 rtl/lane_deskew_if.sv | 28 ++
 rtl/lane_deskew.sv | 183 ++++++++++++++++++
 tb/tb_lane_deskew.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lane_deskew_if.sv
// Bundles the decoder-facing inputs and framing-facing outputs of the
// two-lane deskew stage. The decoder side drives through the master modport;
// the deskew block sits on the slave modport.
interface lane_deskew_if;
    logic       enable_deskew;
    logic [7:0] lane_0_rx;
    logic [7:0] lane_1_rx;
    logic       data_os;
    logic [7:0] lane_0_rx_dsk;
    logic [7:0] lane_1_rx_dsk;
    logic       data_os_dsk;
    logic       deskew_done;
    logic       deskew_err;
    logic [3:0] skew;
    logic       lead_lane;

    modport master (
        output enable_deskew, lane_0_rx, lane_1_rx, data_os,
        input  lane_0_rx_dsk, lane_1_rx_dsk, data_os_dsk,
        input  deskew_done, deskew_err, skew, lead_lane
    );

    modport slave (
        input  enable_deskew, lane_0_rx, lane_1_rx, data_os,
        output lane_0_rx_dsk, lane_1_rx_dsk, data_os_dsk,
        output deskew_done, deskew_err, skew, lead_lane
    );
endinterface

// File: rtl/lane_deskew.sv
// Two-lane deskew stage. Measures the distance between one alignment marker
// per lane and delays the leading lane by that many byte cycles so the pair
// leaves byte-aligned. data_os travels with lane 0.
module lane_deskew #(
    parameter int         MAX_SKEW = 7,
    parameter logic [7:0] MARKER   = 8'hF0
) (
    input logic           enc_clk,
    input logic           rst,
    lane_deskew_if.slave  dsk
);

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        WAIT0,
        WAIT1,
        LOCKED,
        ERROR
    } stateT;

    stateT      state_q, state_d;
    logic [3:0] skew_q, skew_d;
    logic       leadLane_q, leadLane_d;
    logic [3:0] cnt_q, cnt_d;

    logic [7:0] lane0Dly_q [1:MAX_SKEW];
    logic [7:0] lane1Dly_q [1:MAX_SKEW];
    logic       osDly_q    [1:MAX_SKEW];

    logic [7:0] lane0Dsk_q, lane1Dsk_q;
    logic       osDsk_q;

    logic [7:0] lane0Tap, lane1Tap;
    logic       osTap;
    logic       hit0, hit1;

    assign hit0 = dsk.data_os && (dsk.lane_0_rx == MARKER);
    assign hit1 = dsk.data_os && (dsk.lane_1_rx == MARKER);

    // Delay lines shift unconditionally; tap i holds the input from i cycles ago.
    always_ff @(posedge enc_clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i <= MAX_SKEW; i++) begin
                lane0Dly_q[i] <= '0;
                lane1Dly_q[i] <= '0;
                osDly_q[i]    <= 1'b0;
            end
        end else begin
            lane0Dly_q[1] <= dsk.lane_0_rx;
            lane1Dly_q[1] <= dsk.lane_1_rx;
            osDly_q[1]    <= dsk.data_os;
            for (int i = 2; i <= MAX_SKEW; i++) begin
                lane0Dly_q[i] <= lane0Dly_q[i-1];
                lane1Dly_q[i] <= lane1Dly_q[i-1];
                osDly_q[i]    <= osDly_q[i-1];
            end
        end
    end

    // Lock-search state and measured skew registers.
    always_ff @(posedge enc_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            skew_q     <= '0;
            leadLane_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            skew_q     <= skew_d;
            leadLane_q <= leadLane_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state logic: marker search, lag counting, lock and overflow.
    always_comb begin
        state_d    = state_q;
        skew_d     = skew_q;
        leadLane_d = leadLane_q;
        cnt_d      = cnt_q;
        if (!dsk.enable_deskew) begin
            state_d    = IDLE;
            skew_d     = '0;
            leadLane_d = 1'b0;
            cnt_d      = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d    = SEARCH;
                    skew_d     = '0;
                    leadLane_d = 1'b0;
                    cnt_d      = '0;
                end
                SEARCH: begin
                    if (hit0 && hit1) begin
                        state_d    = LOCKED;
                        skew_d     = '0;
                        leadLane_d = 1'b0;
                    end else if (hit0) begin
                        state_d    = WAIT1;
                        leadLane_d = 1'b0;
                        cnt_d      = 4'd1;
                    end else if (hit1) begin
                        state_d    = WAIT0;
                        leadLane_d = 1'b1;
                        cnt_d      = 4'd1;
                    end
                end
                WAIT1: begin
                    if (hit1) begin
                        state_d = LOCKED;
                        skew_d  = cnt_q;
                    end else if (cnt_q == 4'(MAX_SKEW)) begin
                        state_d = ERROR;
                        skew_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                WAIT0: begin
                    if (hit0) begin
                        state_d = LOCKED;
                        skew_d  = cnt_q;
                    end else if (cnt_q == 4'(MAX_SKEW)) begin
                        state_d = ERROR;
                        skew_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                LOCKED: begin
                    state_d = LOCKED;
                end
                ERROR: begin
                    skew_d = '0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Tap select follows the next-cycle skew so the switch at lock is immediate.
    always_comb begin
        lane0Tap = dsk.lane_0_rx;
        lane1Tap = dsk.lane_1_rx;
        osTap    = dsk.data_os;
        for (int i = 1; i <= MAX_SKEW; i++) begin
            if (skew_d == 4'(i)) begin
                if (!leadLane_d) begin
                    lane0Tap = lane0Dly_q[i];
                    osTap    = osDly_q[i];
                end else begin
                    lane1Tap = lane1Dly_q[i];
                end
            end
        end
    end

    // Registered aligned outputs.
    always_ff @(posedge enc_clk or negedge rst) begin
        if (!rst) begin
            lane0Dsk_q <= '0;
            lane1Dsk_q <= '0;
            osDsk_q    <= 1'b0;
        end else begin
            lane0Dsk_q <= lane0Tap;
            lane1Dsk_q <= lane1Tap;
            osDsk_q    <= osTap;
        end
    end

    assign dsk.lane_0_rx_dsk = lane0Dsk_q;
    assign dsk.lane_1_rx_dsk = lane1Dsk_q;
    assign dsk.data_os_dsk   = osDsk_q;
    assign dsk.deskew_done   = (state_q == LOCKED);
    assign dsk.deskew_err    = (state_q == ERROR);
    assign dsk.skew          = skew_q;
    assign dsk.lead_lane     = leadLane_q;

endmodule

// File: tb/tb_lane_deskew.sv
// Self-checking bench for lane_deskew: directed marker scenarios plus a
// randomized run, all compared against a timestamp-based reference model.
module tb_lane_deskew;

    localparam int         MAX_SKEW = 7;
    localparam logic [7:0] MARKER   = 8'hF0;
    localparam int         HIST     = 4096;

    logic enc_clk;
    logic rst;

    lane_deskew_if dskIf ();

    lane_deskew #(
        .MAX_SKEW (MAX_SKEW),
        .MARKER   (MARKER)
    ) dut (
        .enc_clk (enc_clk),
        .rst     (rst),
        .dsk     (dskIf)
    );

    int compareCount;
    int mismatchCount;

    int h0Hist [0:HIST-1];
    int h1Hist [0:HIST-1];
    int osHist [0:HIST-1];
    int cyc;
    int histFloor;

    int mActive;
    int mLeadTime;
    int mLocked;
    int mErr;
    int mSkew;
    int mLead;

    // Free-running byte clock.
    initial begin
        enc_clk = 1'b0;
        forever #5 enc_clk = ~enc_clk;
    end

    task automatic checkOutput(input string tag, input int obs, input int exp);
        compareCount++;
        if (obs != exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] rndByte();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == MARKER) b = 8'h0F;
        return b;
    endfunction

    function automatic int histAt(input int which, input int idx);
        if (idx < histFloor) return 0;
        if (which == 0) return h0Hist[idx];
        if (which == 1) return h1Hist[idx];
        return osHist[idx];
    endfunction

    task automatic modelClear();
        mActive   = 0;
        mLeadTime = -1;
        mLocked   = 0;
        mErr      = 0;
        mSkew     = 0;
        mLead     = 0;
    endtask

    // Marker bookkeeping by timestamp: lead marker time, then the lag distance.
    task automatic modelStep(input logic en, input logic [7:0] b0, input logic [7:0] b1,
                             input logic os, input int k);
        bit h0, h1, lagHit;
        h0 = os && (b0 == MARKER);
        h1 = os && (b1 == MARKER);
        if (!en) begin
            modelClear();
        end else if (mActive == 0) begin
            mActive = 1;
        end else if (mLocked != 0 || mErr != 0) begin
            mActive = 1;
        end else if (mLeadTime < 0) begin
            if (h0 && h1) begin
                mLocked = 1;
                mSkew   = 0;
                mLead   = 0;
            end else if (h0) begin
                mLeadTime = k;
                mLead     = 0;
            end else if (h1) begin
                mLeadTime = k;
                mLead     = 1;
            end
        end else begin
            lagHit = (mLead == 1) ? h0 : h1;
            if (lagHit) begin
                mLocked = 1;
                mSkew   = k - mLeadTime;
            end else if (k - mLeadTime >= MAX_SKEW) begin
                mErr = 1;
            end
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [7:0] b0, input logic [7:0] b1,
                                 input logic os);
        int k, d0, d1;
        dskIf.enable_deskew = en;
        dskIf.lane_0_rx     = b0;
        dskIf.lane_1_rx     = b1;
        dskIf.data_os       = os;
        @(posedge enc_clk);
        k = cyc;
        h0Hist[k] = int'(b0);
        h1Hist[k] = int'(b1);
        osHist[k] = int'(os);
        modelStep(en, b0, b1, os, k);
        cyc++;
        #1;
        d0 = (mLead == 0) ? mSkew : 0;
        d1 = (mLead == 1) ? mSkew : 0;
        checkOutput("lane0_dsk", int'(dskIf.lane_0_rx_dsk), histAt(0, k - d0));
        checkOutput("lane1_dsk", int'(dskIf.lane_1_rx_dsk), histAt(1, k - d1));
        checkOutput("os_dsk", int'(dskIf.data_os_dsk), histAt(2, k - d0));
        checkOutput("done", int'(dskIf.deskew_done), mLocked);
        checkOutput("err", int'(dskIf.deskew_err), mErr);
        checkOutput("skew", int'(dskIf.skew), mSkew);
        checkOutput("lead", int'(dskIf.lead_lane), mLead);
    endtask

    task automatic filler(input int n, input logic en);
        for (int i = 0; i < n; i++)
            applyStimulus(en, rndByte(), rndByte(), 1'($urandom));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_lane0"}, int'(dskIf.lane_0_rx_dsk), 0);
        checkOutput({tag, "_lane1"}, int'(dskIf.lane_1_rx_dsk), 0);
        checkOutput({tag, "_os"}, int'(dskIf.data_os_dsk), 0);
        checkOutput({tag, "_done"}, int'(dskIf.deskew_done), 0);
        checkOutput({tag, "_err"}, int'(dskIf.deskew_err), 0);
        checkOutput({tag, "_skew"}, int'(dskIf.skew), 0);
        checkOutput({tag, "_lead"}, int'(dskIf.lead_lane), 0);
    endtask

    // Directed scenarios followed by a randomized run and a mid-lock reset.
    initial begin
        logic en;
        logic [7:0] b0, b1;
        compareCount  = 0;
        mismatchCount = 0;
        cyc           = 0;
        histFloor     = 0;
        modelClear();

        rst                 = 1'b0;
        dskIf.enable_deskew = 1'b0;
        dskIf.lane_0_rx     = 8'h00;
        dskIf.lane_1_rx     = 8'h00;
        dskIf.data_os       = 1'b0;
        repeat (2) @(posedge enc_clk);
        #1;
        checkAllZero("reset");
        @(negedge enc_clk);
        rst = 1'b1;
        histFloor = cyc;

        // Pass-through while deskew is disabled.
        applyStimulus(1'b0, 8'h11, 8'h22, 1'b0);
        checkOutput("pass_lane0", int'(dskIf.lane_0_rx_dsk), 8'h11);
        checkOutput("pass_lane1", int'(dskIf.lane_1_rx_dsk), 8'h22);
        filler(3, 1'b0);

        // Zero skew.
        applyStimulus(1'b1, rndByte(), rndByte(), 1'b0);
        filler(2, 1'b1);
        applyStimulus(1'b1, MARKER, MARKER, 1'b1);
        checkOutput("zs_done", int'(dskIf.deskew_done), 1);
        checkOutput("zs_m0", int'(dskIf.lane_0_rx_dsk), MARKER);
        checkOutput("zs_m1", int'(dskIf.lane_1_rx_dsk), MARKER);
        filler(5, 1'b1);

        // Lane 0 leads by 3.
        filler(1, 1'b0);
        filler(2, 1'b1);
        applyStimulus(1'b1, MARKER, rndByte(), 1'b1);
        filler(2, 1'b1);
        applyStimulus(1'b1, rndByte(), MARKER, 1'b1);
        checkOutput("l0_skew", int'(dskIf.skew), 3);
        checkOutput("l0_lead", int'(dskIf.lead_lane), 0);
        checkOutput("l0_done", int'(dskIf.deskew_done), 1);
        checkOutput("l0_m0", int'(dskIf.lane_0_rx_dsk), MARKER);
        checkOutput("l0_m1", int'(dskIf.lane_1_rx_dsk), MARKER);
        applyStimulus(1'b1, MARKER, rndByte(), 1'b1);
        filler(10, 1'b1);

        // Lane 1 leads by MAX_SKEW.
        filler(1, 1'b0);
        filler(2, 1'b1);
        applyStimulus(1'b1, rndByte(), MARKER, 1'b1);
        filler(MAX_SKEW - 1, 1'b1);
        applyStimulus(1'b1, MARKER, rndByte(), 1'b1);
        checkOutput("l1_skew", int'(dskIf.skew), MAX_SKEW);
        checkOutput("l1_lead", int'(dskIf.lead_lane), 1);
        checkOutput("l1_m0", int'(dskIf.lane_0_rx_dsk), MARKER);
        checkOutput("l1_m1", int'(dskIf.lane_1_rx_dsk), MARKER);
        filler(10, 1'b1);

        // Overflow with no lagging marker.
        filler(1, 1'b0);
        filler(2, 1'b1);
        applyStimulus(1'b1, MARKER, rndByte(), 1'b1);
        filler(MAX_SKEW - 1, 1'b1);
        checkOutput("ovf_early", int'(dskIf.deskew_err), 0);
        filler(1, 1'b1);
        checkOutput("ovf_set", int'(dskIf.deskew_err), 1);
        applyStimulus(1'b1, MARKER, MARKER, 1'b1);
        checkOutput("ovf_sticky", int'(dskIf.deskew_err), 1);
        filler(1, 1'b0);
        checkOutput("ovf_clear", int'(dskIf.deskew_err), 0);

        // Abort in the middle of the lag count, then relock with skew 1.
        filler(2, 1'b1);
        applyStimulus(1'b1, MARKER, rndByte(), 1'b1);
        filler(1, 1'b1);
        filler(1, 1'b0);
        checkOutput("abort_done", int'(dskIf.deskew_done), 0);
        filler(2, 1'b1);
        applyStimulus(1'b1, MARKER, rndByte(), 1'b1);
        applyStimulus(1'b1, rndByte(), MARKER, 1'b1);
        checkOutput("abort_skew", int'(dskIf.skew), 1);
        checkOutput("abort_done2", int'(dskIf.deskew_done), 1);
        filler(4, 1'b1);

        // Randomized run with frequent markers and occasional disables.
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 99) < 4) ? 1'b0 : 1'b1;
            b0 = ($urandom_range(0, 4) == 0) ? MARKER : rndByte();
            b1 = ($urandom_range(0, 4) == 0) ? MARKER : rndByte();
            applyStimulus(en, b0, b1, 1'($urandom));
        end

        // Asynchronous reset while locked.
        filler(1, 1'b0);
        filler(2, 1'b1);
        applyStimulus(1'b1, rndByte(), MARKER, 1'b1);
        filler(1, 1'b1);
        applyStimulus(1'b1, MARKER, rndByte(), 1'b1);
        checkOutput("ar_skew", int'(dskIf.skew), 2);
        filler(3, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        checkAllZero("async");
        modelClear();
        @(negedge enc_clk);
        rst = 1'b1;
        histFloor = cyc;
        filler(3, 1'b1);
        checkOutput("ar_nolock", int'(dskIf.deskew_done), 0);
        applyStimulus(1'b1, rndByte(), MARKER, 1'b1);
        filler(1, 1'b1);
        applyStimulus(1'b1, MARKER, rndByte(), 1'b1);
        checkOutput("ar_relock", int'(dskIf.skew), 2);
        filler(5, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
